// File: rtl/prio_irq_encoder.sv
// ---------------------------------------------------------------------------
// prio_irq_encoder
//
// Registered priority interrupt encoder with HC148-style cascade pins.
//
// Request lines are normalised to active-high and latched into a pending
// vector. Capture is either level based or rising-edge based. The highest
// eligible pending index (N-1 highest) is presented on code/valid and held
// until the consumer acknowledges it or the enable input is withdrawn.
// Acknowledging clears the presented pending bit. A request that arrives at
// the same edge as that clear keeps the bit pending.
//
// Parameters
//   N          number of request lines, 2..32
//   ACTIVE_LOW 1: req bits asserted low (HC148 polarity), 0: asserted high
//   EDGE       0: level capture, 1: rising-edge capture of the asserted level
//
// Ports
//   clk    in   single clock, all state updates on its rising edge
//   rst    in   asynchronous, active-high reset
//   ei_n   in   enable input, active low; when high nothing is eligible
//   req    in   [N] request lines, synchronous to clk
//   mask   in   [N] 1 excludes that index from selection (it still latches)
//   ack    in   consumer accepts the presented code (ignored while idle)
//   code   out  [W] binary index of the presented request, held while idle
//   valid  out  code is being presented
//   gs_n   out  group select, active low, always the inverse of valid
//   eo_n   out  enable output for cascading, low when enabled, nothing is
//               eligible and the encoder is idle
//
// Every output is driven straight from a flop. No input reaches an output
// through combinational logic only.
// ---------------------------------------------------------------------------
module prio_irq_encoder #(
    parameter int N          = 8,
    parameter int ACTIVE_LOW = 1,
    parameter int EDGE       = 0,
    localparam int W         = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ei_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         ack,
    output logic [W-1:0] code,
    output logic         valid,
    output logic         gs_n,
    output logic         eo_n
);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t       state;
    state_t       state_nx;

    // -----------------------------------------------------------------------
    // Request capture signals
    // -----------------------------------------------------------------------
    logic [N-1:0] r;           // request lines in true (active-high) polarity
    logic [N-1:0] r_prev;      // r from the previous edge, for edge detect
    logic [N-1:0] set_vec;     // bits that become pending at this edge
    logic [N-1:0] clr_vec;     // bit retired by an accepted ack
    logic [N-1:0] pending;
    logic [N-1:0] pending_nx;
    logic [N-1:0] eligible;

    // -----------------------------------------------------------------------
    // Selection and next-output signals
    // -----------------------------------------------------------------------
    logic         any_eligible;
    logic [W-1:0] win_idx;
    logic [W-1:0] code_nx;
    logic         valid_nx;
    logic         eo_n_nx;

    // -----------------------------------------------------------------------
    // Normalisation and capture qualification
    // -----------------------------------------------------------------------
    assign r = (ACTIVE_LOW != 0) ? ~req : req;

    // In edge mode a held line produces one pending event only. It must drop
    // for at least one edge before it can request again.
    assign set_vec = (EDGE != 0) ? (r & ~r_prev) : r;

    // The enable input gates selection only. Capture into pending goes on
    // regardless, so nothing is lost while the encoder is disabled.
    assign eligible     = ei_n ? '0 : (pending & ~mask);
    assign any_eligible = |eligible;

    // -----------------------------------------------------------------------
    // Priority selection: scan upward so the highest set index wins.
    // -----------------------------------------------------------------------
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (eligible[i]) begin
                win_idx = W'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_nx = state;
        code_nx  = code;
        valid_nx = valid;
        clr_vec  = '0;

        unique case (state)
            IDLE: begin
                // ack is ignored here. code keeps its last value until a new
                // winner is loaded.
                valid_nx = 1'b0;
                if (any_eligible) begin
                    code_nx  = win_idx;
                    valid_nx = 1'b1;
                    state_nx = PRESENT;
                end
            end

            PRESENT: begin
                // code is frozen here. A new higher-priority request or a
                // mask change waits for the next arbitration in IDLE.
                if (ei_n) begin
                    // The enable is withdrawn, so stop presenting. The
                    // un-acked index stays pending and is offered again
                    // once enabled.
                    valid_nx = 1'b0;
                    state_nx = IDLE;
                end else if (ack) begin
                    clr_vec[code] = 1'b1;
                    valid_nx      = 1'b0;
                    state_nx      = IDLE;
                end
            end

            default: begin
                valid_nx = 1'b0;
                state_nx = IDLE;
            end
        endcase

        // The set term is ORed in last. A fresh request at the same edge as
        // the ack therefore keeps the bit pending.
        pending_nx = (pending & ~clr_vec) | set_vec;

        // The cascade enable passes downstream only when this stage is
        // enabled, has nothing to offer and is not about to present.
        eo_n_nx = ~(~ei_n & ~any_eligible & (state_nx == IDLE));
    end

    // -----------------------------------------------------------------------
    // State, capture and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: pending is a plain register vector, not a RAM. Clearing
            // it in reset discards any request that was captured or being
            // presented when reset hit.
            state   <= IDLE;
            pending <= '0;
            r_prev  <= '0;
            code    <= '0;
            valid   <= 1'b0;
            gs_n    <= 1'b1;
            eo_n    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments here make every register sample
            // the pre-edge values, whatever order the statements are in.
            state   <= state_nx;
            pending <= pending_nx;
            r_prev  <= r;
            code    <= code_nx;
            valid   <= valid_nx;
            gs_n    <= ~valid_nx;
            eo_n    <= eo_n_nx;
        end
    end

endmodule
